// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons sharing one runtime configuration register file.
// Each channel has its own weight, refractory counter and membrane; spikes are counted globally.
module lif_neuron_array #(
  parameter int N_CH        = 4,
  parameter int V_W         = 8,
  parameter int W_W         = 4,
  parameter int THRESH_INIT = 200,
  parameter int LEAK_INIT   = 1,
  parameter int REFR_INIT   = 2,
  parameter int W_INIT      = 8,
  localparam int AW = $clog2(N_CH + 4),
  localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N_CH-1:0] spike_in,
  input  logic            cfg_we,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [V_W-1:0]  cfg_data,
  input  logic [SW-1:0]   v_sel,
  output logic [N_CH-1:0] spike_out,
  output logic [V_W-1:0]  v_out,
  output logic [15:0]     spike_cnt
);

  logic [V_W-1:0] thresh;
  logic [V_W-1:0] leak;
  logic [3:0]     refr;
  logic           mode;
  logic [W_W-1:0] weight [N_CH];

  logic [V_W-1:0] v [N_CH];
  logic [3:0]     refr_cnt [N_CH];

  logic [V_W-1:0] leak_amt [N_CH];
  logic [V_W-1:0] v_leak [N_CH];
  logic [V_W:0]   v_sum [N_CH];
  logic [V_W-1:0] v_int [N_CH];
  logic [N_CH-1:0] fire;
  logic [16:0]    pop;
  logic [16:0]    cnt_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      thresh <= V_W'(THRESH_INIT);
      leak   <= V_W'(LEAK_INIT);
      refr   <= 4'(REFR_INIT);
      mode   <= 1'b0;
      for (int i = 0; i < N_CH; i++) weight[i] <= W_W'(W_INIT);
    end else if (cfg_we) begin
      case (cfg_addr)
        AW'(0):  thresh <= cfg_data;
        AW'(1):  leak   <= cfg_data;
        AW'(2):  refr   <= cfg_data[3:0];
        AW'(3):  mode   <= cfg_data[0];
        default: begin
          // Addresses past the last weight slot match no channel and are dropped.
          for (int i = 0; i < N_CH; i++)
            if (int'(cfg_addr) == i + 4) weight[i] <= cfg_data[W_W-1:0];
        end
      endcase
    end
  end

  // Leak floors at zero, then the weighted input saturates at full scale rather than wrapping.
  always_comb begin
    fire = '0;
    for (int i = 0; i < N_CH; i++) begin
      leak_amt[i] = mode ? (v[i] >> leak[2:0]) : leak;
      v_leak[i]   = (v[i] > leak_amt[i]) ? v[i] - leak_amt[i] : '0;
      v_sum[i]    = {1'b0, v_leak[i]} + (spike_in[i] ? (V_W+1)'(weight[i]) : '0);
      v_int[i]    = v_sum[i][V_W] ? '1 : v_sum[i][V_W-1:0];
      fire[i]     = (refr_cnt[i] == 4'd0) && (v_int[i] >= thresh);
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_CH; i++) pop = pop + 17'(fire[i]);
  end

  assign cnt_sum = {1'b0, spike_cnt} + pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        v[i]        <= '0;
        refr_cnt[i] <= '0;
      end
      spike_out <= '0;
      spike_cnt <= '0;
    end else if (en) begin
      for (int i = 0; i < N_CH; i++) begin
        if (refr_cnt[i] != 4'd0) begin
          v[i]        <= '0;
          refr_cnt[i] <= refr_cnt[i] - 4'd1;
        end else if (fire[i]) begin
          v[i]        <= '0;
          refr_cnt[i] <= refr;
        end else begin
          v[i] <= v_int[i];
        end
      end
      spike_out <= fire;
      spike_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end else begin
      spike_out <= '0;
    end
  end

  // Out-of-range selections match no channel and read as zero.
  always_comb begin
    v_out = '0;
    for (int i = 0; i < N_CH; i++)
      if (int'(v_sel) == i) v_out = v[i];
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench for lif_neuron_array: spec-level behavioural model compared every cycle,
// plus hand-computed literal checkpoints. Uses 3 channels so out-of-range address/select exist.
module tb_lif_neuron_array;

  localparam int N_CH = 3;
  localparam int V_W  = 8;
  localparam int W_W  = 4;
  localparam int AW   = $clog2(N_CH + 4);
  localparam int SW   = $clog2(N_CH);
  localparam int VMAX = (1 << V_W) - 1;

  logic            clk;
  logic            rst;
  logic            en;
  logic [N_CH-1:0] spike_in;
  logic            cfg_we;
  logic [AW-1:0]   cfg_addr;
  logic [V_W-1:0]  cfg_data;
  logic [SW-1:0]   v_sel;
  logic [N_CH-1:0] spike_out;
  logic [V_W-1:0]  v_out;
  logic [15:0]     spike_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 0;

  int m_v [N_CH];
  int m_rc [N_CH];
  int m_w [N_CH];
  int m_thresh, m_leak, m_refr, m_mode, m_cnt;
  logic [N_CH-1:0] m_so;

  lif_neuron_array #(.N_CH(N_CH), .V_W(V_W), .W_W(W_W)) dut (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .v_sel(v_sel),
    .spike_out(spike_out), .v_out(v_out), .spike_cnt(spike_cnt)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Reference model: dynamics first with the old config, then the config write lands.
  always @(posedge clk) begin : model_step
    int l, vl, vi, fired, a;
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        m_v[i] = 0; m_rc[i] = 0; m_w[i] = 8;
      end
      m_thresh = 200; m_leak = 1; m_refr = 2; m_mode = 0; m_cnt = 0; m_so = '0;
    end else begin
      if (en) begin
        fired = 0;
        for (int i = 0; i < N_CH; i++) begin
          if (m_rc[i] > 0) begin
            m_v[i] = 0; m_rc[i] = m_rc[i] - 1; m_so[i] = 1'b0;
          end else begin
            l  = (m_mode != 0) ? (m_v[i] >> (m_leak % 8)) : m_leak;
            vl = m_v[i] - l;
            if (vl < 0) vl = 0;
            vi = vl + (spike_in[i] ? m_w[i] : 0);
            if (vi > VMAX) vi = VMAX;
            if (vi >= m_thresh) begin
              m_so[i] = 1'b1; m_v[i] = 0; m_rc[i] = m_refr; fired = fired + 1;
            end else begin
              m_so[i] = 1'b0; m_v[i] = vi;
            end
          end
        end
        m_cnt = m_cnt + fired;
        if (m_cnt > 65535) m_cnt = 65535;
      end else begin
        m_so = '0;
      end
      if (cfg_we) begin
        a = int'(cfg_addr);
        if (a == 0) m_thresh = int'(cfg_data);
        else if (a == 1) m_leak = int'(cfg_data);
        else if (a == 2) m_refr = int'(cfg_data) % 16;
        else if (a == 3) m_mode = int'(cfg_data) % 2;
        else if (a >= 4 && a < 4 + N_CH) m_w[a-4] = int'(cfg_data) % (1 << W_W);
      end
    end
  end

  task automatic checkOutput();
    int exp_v;
    exp_v = 0;
    if (int'(v_sel) < N_CH) exp_v = m_v[v_sel];
    n_tests++;
    if (spike_out !== m_so) begin
      n_fail++;
      $display("[TB] FAIL spike_out t=%0t: got %b expected %b", $time, spike_out, m_so);
    end
    n_tests++;
    if (v_out !== V_W'(exp_v)) begin
      n_fail++;
      $display("[TB] FAIL v_out sel=%0d t=%0t: got %0d expected %0d", v_sel, $time, v_out, exp_v);
    end
    n_tests++;
    if (spike_cnt !== 16'(m_cnt)) begin
      n_fail++;
      $display("[TB] FAIL spike_cnt t=%0t: got %0d expected %0d", $time, spike_cnt, m_cnt);
    end
  endtask

  always @(negedge clk) if (chk_on) checkOutput();

  task automatic checkLit(input string name, input int dut_val, input int mdl_val, input int exp_val);
    n_tests++;
    if (dut_val != exp_val) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, dut_val, exp_val);
    end
    n_tests++;
    if (mdl_val != exp_val) begin
      n_fail++;
      $display("[TB] FAIL model_%s: got %0d expected %0d", name, mdl_val, exp_val);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [N_CH-1:0] s, input int ncyc);
    rst = 0; cfg_we = 0; en = e; spike_in = s;
    repeat (ncyc) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic cfgWrite(input int a, input int d, input logic e, input logic [N_CH-1:0] s);
    rst = 0; en = e; spike_in = s;
    cfg_we = 1; cfg_addr = AW'(a); cfg_data = V_W'(d);
    @(posedge clk); #2;
    cfg_we = 0;
  endtask

  task automatic doReset();
    rst = 1; en = 1; spike_in = '1; cfg_we = 0;
    @(posedge clk); #2;
    rst = 0;
  endtask

  initial begin
    rst = 1; en = 0; spike_in = '0; cfg_we = 0; cfg_addr = '0; cfg_data = '0; v_sel = '0;
    @(posedge clk); #2;
    chk_on = 1;

    $display("[TB] integrate to threshold with defaults");
    doReset();
    checkLit("rst_cnt", int'(spike_cnt), m_cnt, 0);
    checkLit("rst_v0", int'(v_out), m_v[0], 0);
    applyStimulus(1, 3'b001, 1);
    checkLit("t1_v0_c1", int'(v_out), m_v[0], 8);
    applyStimulus(1, 3'b001, 27);
    checkLit("t1_v0_c28", int'(v_out), m_v[0], 197);
    checkLit("t1_so_c28", int'(spike_out), int'(m_so), 0);
    applyStimulus(1, 3'b001, 1);
    checkLit("t1_so_c29", int'(spike_out), int'(m_so), 1);
    checkLit("t1_v0_c29", int'(v_out), m_v[0], 0);
    applyStimulus(1, 3'b001, 2);
    checkLit("t1_v0_refr", int'(v_out), m_v[0], 0);
    checkLit("t1_so_refr", int'(spike_out), int'(m_so), 0);
    applyStimulus(1, 3'b001, 1);
    checkLit("t1_v0_c32", int'(v_out), m_v[0], 8);

    $display("[TB] shift leak decay");
    doReset();
    cfgWrite(0, 255, 0, 3'b000);
    cfgWrite(1, 0, 0, 3'b000);
    cfgWrite(4, 10, 0, 3'b000);
    applyStimulus(1, 3'b001, 10);
    checkLit("t2_preload", int'(v_out), m_v[0], 100);
    cfgWrite(3, 1, 0, 3'b000);
    cfgWrite(1, 2, 0, 3'b000);
    applyStimulus(1, 3'b000, 1);
    checkLit("t2_d1", int'(v_out), m_v[0], 75);
    applyStimulus(1, 3'b000, 1);
    checkLit("t2_d2", int'(v_out), m_v[0], 57);
    applyStimulus(1, 3'b000, 1);
    checkLit("t2_d3", int'(v_out), m_v[0], 43);
    applyStimulus(1, 3'b000, 30);
    checkLit("t2_settle", int'(v_out), m_v[0], 3);
    cfgWrite(3, 0, 0, 3'b000);
    cfgWrite(1, 1, 0, 3'b000);
    applyStimulus(1, 3'b000, 6);
    checkLit("t2_floor", int'(v_out), m_v[0], 0);

    $display("[TB] saturation at full scale");
    doReset();
    cfgWrite(4, 15, 0, 3'b000);
    cfgWrite(1, 0, 0, 3'b000);
    cfgWrite(0, 255, 0, 3'b000);
    applyStimulus(1, 3'b001, 16);
    checkLit("t3_v0_240", int'(v_out), m_v[0], 240);
    applyStimulus(1, 3'b001, 1);
    checkLit("t3_fire_255", int'(spike_out), int'(m_so), 1);
    applyStimulus(1, 3'b001, 2);
    cfgWrite(4, 10, 0, 3'b000);
    applyStimulus(1, 3'b001, 25);
    checkLit("t3_v0_250", int'(v_out), m_v[0], 250);
    cfgWrite(4, 15, 0, 3'b000);
    applyStimulus(1, 3'b001, 1);
    checkLit("t3_sat_fire", int'(spike_out), int'(m_so), 1);
    checkLit("t3_sat_v0", int'(v_out), m_v[0], 0);
    checkLit("t3_cnt", int'(spike_cnt), m_cnt, 2);

    $display("[TB] zero threshold and counter clamp");
    doReset();
    cfgWrite(0, 0, 0, 3'b000);
    cfgWrite(2, 0, 0, 3'b000);
    applyStimulus(1, 3'b111, 2);
    checkLit("t4_so", int'(spike_out), int'(m_so), 7);
    checkLit("t4_cnt6", int'(spike_cnt), m_cnt, 6);
    applyStimulus(1, 3'b000, 1);
    checkLit("t4_cnt9", int'(spike_cnt), m_cnt, 9);
    applyStimulus(1, 3'b111, 21840);
    checkLit("t4_cnt_near", int'(spike_cnt), m_cnt, 65529);
    applyStimulus(1, 3'b111, 2);
    checkLit("t4_cnt_max", int'(spike_cnt), m_cnt, 65535);
    applyStimulus(1, 3'b111, 3);
    checkLit("t4_cnt_clamp", int'(spike_cnt), m_cnt, 65535);
    applyStimulus(0, 3'b111, 1);
    checkLit("t4_en0_so", int'(spike_out), int'(m_so), 0);

    $display("[TB] config write timing and bad address");
    doReset();
    applyStimulus(1, 3'b001, 6);
    checkLit("t5_v0_43", int'(v_out), m_v[0], 43);
    cfgWrite(0, 50, 1, 3'b001);
    checkLit("t5_old_thresh_so", int'(spike_out), int'(m_so), 0);
    checkLit("t5_old_thresh_v0", int'(v_out), m_v[0], 50);
    applyStimulus(1, 3'b001, 1);
    checkLit("t5_new_thresh_so", int'(spike_out), int'(m_so), 1);
    cfgWrite(N_CH + 4, 0, 1, 3'b000);
    for (int k = 0; k < 8; k++) begin
      v_sel = SW'(k % 4);
      applyStimulus(1, 3'b011, 1);
    end
    checkLit("t5_vsel_oor", int'(v_out), 0, 0);
    v_sel = '0;
    applyStimulus(1, 3'b011, 4);

    $display("[TB] reset mid-refractory and enable freeze");
    doReset();
    applyStimulus(1, 3'b001, 29);
    checkLit("t6_fire", int'(spike_out), int'(m_so), 1);
    applyStimulus(1, 3'b001, 1);
    rst = 1; en = 1; spike_in = 3'b111; cfg_we = 1; cfg_addr = '0; cfg_data = '0;
    @(posedge clk); #2;
    rst = 0; cfg_we = 0;
    checkLit("t6_rst_so", int'(spike_out), int'(m_so), 0);
    checkLit("t6_rst_cnt", int'(spike_cnt), m_cnt, 0);
    checkLit("t6_rst_v0", int'(v_out), m_v[0], 0);
    applyStimulus(1, 3'b001, 1);
    checkLit("t6_after_rst_v0", int'(v_out), m_v[0], 8);
    applyStimulus(1, 3'b001, 28);
    checkLit("t6_fire2", int'(spike_out), int'(m_so), 1);
    applyStimulus(0, 3'b111, 10);
    checkLit("t6_frozen_so", int'(spike_out), int'(m_so), 0);
    checkLit("t6_frozen_cnt", int'(spike_cnt), m_cnt, 1);
    applyStimulus(1, 3'b001, 2);
    checkLit("t6_refr_held_v0", int'(v_out), m_v[0], 0);
    applyStimulus(1, 3'b001, 1);
    checkLit("t6_resume_v0", int'(v_out), m_v[0], 8);

    @(negedge clk);
    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
